// File: rtl/interrupt_sequencer_pkg.sv
// Shared CPU definitions for the interrupt sequencer:
// FSM state encoding, handler vector and interrupt ID width.
package interrupt_sequencer_pkg;

  localparam int ID_W = 8;
  localparam int INT_VECTOR_ADDR = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_RETURN  = 2'd2
  } int_state_e;

endpackage

// File: rtl/interrupt_sequencer.sv
// Takes controller interrupt requests at instruction boundaries,
// redirects to the vector, and restores the saved PC on reti.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] VECTOR_ADDR =
    ADDR_W'(INT_VECTOR_ADDR),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intCPU,
  input  logic [ID_W-1:0]   intID,
  input  logic              boundary_valid,
  input  logic [ADDR_W-1:0] boundary_pc,
  input  logic              reti_commit,
  output logic              intDisabled,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [ID_W-1:0]   cur_id,
  output logic [CNT_W-1:0]  int_count,
  output logic              spurious_reti
);

  int_state_e        state_q;
  logic              int_dis_q;
  logic              rdr_vld_q;
  logic [ADDR_W-1:0] rdr_pc_q;
  logic [ADDR_W-1:0] epc_q;
  logic [ID_W-1:0]   cur_id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              spur_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      int_dis_q <= 1'b0;
      rdr_vld_q <= 1'b0;
      rdr_pc_q  <= '0;
      epc_q     <= '0;
      cur_id_q  <= '0;
      cnt_q     <= '0;
      spur_q    <= 1'b0;
    end else begin
      rdr_vld_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          int_dis_q <= 1'b0;
          if (reti_commit) spur_q <= 1'b1;
          if (intCPU && boundary_valid) begin
            epc_q     <= boundary_pc;
            cur_id_q  <= intID;
            int_dis_q <= 1'b1;
            rdr_vld_q <= 1'b1;
            rdr_pc_q  <= VECTOR_ADDR;
            cnt_q     <= cnt_q + CNT_W'(1);
            state_q   <= ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          if (reti_commit) begin
            rdr_vld_q <= 1'b1;
            rdr_pc_q  <= epc_q;
            state_q   <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          // Re-enable only after the restore redirect is in fetch.
          int_dis_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          int_dis_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign intDisabled    = int_dis_q;
  assign redirect_valid = rdr_vld_q;
  assign redirect_pc    = rdr_pc_q;
  assign epc            = epc_q;
  assign cur_id         = cur_id_q;
  assign int_count      = cnt_q;
  assign spurious_reti  = spur_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed checks for interrupt_sequencer, incl. a
// narrow-counter instance for wrap-around.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        intCPU = 1'b0;
  logic [7:0]  intID = '0;
  logic        bv = 1'b0;
  logic [31:0] bpc = '0;
  logic        reti = 1'b0;

  logic        dis, rv;
  logic [31:0] rpc, epc;
  logic [7:0]  cid;
  logic [15:0] cnt;
  logic        spur;

  logic        s_dis, s_rv;
  logic [31:0] s_rpc, s_epc;
  logic [7:0]  s_cid;
  logic [1:0]  s_cnt;
  logic        s_spur;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  interrupt_sequencer u_dut (
    .clk(clk), .reset(reset),
    .intCPU(intCPU), .intID(intID),
    .boundary_valid(bv), .boundary_pc(bpc),
    .reti_commit(reti),
    .intDisabled(dis), .redirect_valid(rv),
    .redirect_pc(rpc), .epc(epc),
    .cur_id(cid), .int_count(cnt),
    .spurious_reti(spur)
  );

  interrupt_sequencer #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset),
    .intCPU(intCPU), .intID(intID),
    .boundary_valid(bv), .boundary_pc(bpc),
    .reti_commit(reti),
    .intDisabled(s_dis), .redirect_valid(s_rv),
    .redirect_pc(s_rpc), .epc(s_epc),
    .cur_id(s_cid), .int_count(s_cnt),
    .spurious_reti(s_spur)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    intCPU = 1'b0;
    bv = 1'b0;
    reti = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  logic [1:0] wrap_exp [5];

  initial begin
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;

    // reset state
    #12;
    chk("rst_dis", dis, 0);
    chk("rst_rv", rv, 0);
    chk("rst_rpc", rpc, 0);
    chk("rst_epc", epc, 0);
    chk("rst_cid", cid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_spur", spur, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: entry at boundary
    intCPU = 1; intID = 8'd3; bv = 1; bpc = 32'h100;
    tick();
    chk("t1_rv", rv, 1);
    chk("t1_rpc", rpc, 1);
    chk("t1_dis", dis, 1);
    chk("t1_epc", epc, 32'h100);
    chk("t1_cid", cid, 3);
    chk("t1_cnt", cnt, 1);
    idle_in();
    tick();
    chk("t1_rv_drop", rv, 0);
    chk("t1_dis_hold", dis, 1);

    // 3: reti return
    reti = 1;
    tick();
    chk("t3_rv", rv, 1);
    chk("t3_rpc", rpc, 32'h100);
    chk("t3_dis", dis, 1);
    reti = 1'b0;
    intCPU = 1; intID = 8'd9; bv = 1; bpc = 32'h999;
    tick();
    chk("t3_dis_m2", dis, 0);
    chk("t3_rv_m2", rv, 0);
    chk("t3_ret_noentry", epc, 32'h100);
    idle_in();
    tick();
    chk("t3_idle_dis", dis, 0);
    chk("t3_spur", spur, 0);

    // 2: request held without boundary
    intCPU = 1; intID = 8'd5; bv = 0; bpc = 32'h240;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_wait_rv", rv, 0);
      chk("t2_wait_dis", dis, 0);
    end
    bv = 1;
    tick();
    chk("t2_rv", rv, 1);
    chk("t2_epc", epc, 32'h240);
    chk("t2_cid", cid, 5);
    chk("t2_cnt", cnt, 2);
    idle_in();
    tick();
    reti = 1;
    tick();
    chk("t2_ret_rpc", rpc, 32'h240);
    reti = 0;
    tick();
    tick();
    chk("t2_epc_hold", epc, 32'h240);
    chk("t2_cid_hold", cid, 5);

    // 4: spurious reti, then combined with entry
    reti = 1;
    tick();
    chk("t4_rv", rv, 0);
    chk("t4_spur", spur, 1);
    chk("t4_dis", dis, 0);
    reti = 0;
    tick();
    chk("t4_spur_sticky", spur, 1);
    intCPU = 1; intID = 8'd7; bv = 1; bpc = 32'h300;
    reti = 1;
    tick();
    chk("t4_both_rv", rv, 1);
    chk("t4_both_dis", dis, 1);
    chk("t4_both_epc", epc, 32'h300);
    chk("t4_both_cnt", cnt, 3);
    chk("t4_both_spur", spur, 1);
    idle_in();
    tick();

    // 5: async reset mid-handler
    #3;
    reset = 1'b0;
    #1;
    chk("t5_dis", dis, 0);
    chk("t5_rv", rv, 0);
    chk("t5_rpc", rpc, 0);
    chk("t5_epc", epc, 0);
    chk("t5_cid", cid, 0);
    chk("t5_cnt", cnt, 0);
    chk("t5_spur", spur, 0);
    #2;
    reset = 1'b1;
    intCPU = 1; intID = 8'd2; bv = 1; bpc = 32'h44;
    tick();
    chk("t5_re_rv", rv, 1);
    chk("t5_re_epc", epc, 32'h44);
    chk("t5_re_cnt", cnt, 1);
    idle_in();
    tick();

    // 6: counter wrap on CNT_W=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      intCPU = 1; intID = 8'(i + 1); bv = 1;
      bpc = 32'h1000 + 32'(i * 4);
      tick();
      chk("t6_small_cnt", s_cnt, wrap_exp[i]);
      chk("t6_big_cnt", cnt, 16'(i + 1));
      idle_in();
      tick();
      reti = 1;
      tick();
      chk("t6_ret_rpc", rpc, 32'h1000 + 32'(i * 4));
      reti = 0;
      tick();
      chk("t6_ret_dis", dis, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- CPU-side consumer of the interrupt controller's `intCPU`/`intID` request pair.
- Waits for a safe instruction boundary, then:
  - saves the return PC and the interrupt ID,
  - raises `intDisabled`, which acks the controller,
  - redirects fetch to the interrupt vector.
- On `reti` commit it restores the saved PC and re-enables interrupts.
- Sits between the interrupt controller and the CPU fetch/commit logic. Single level only, no nesting.

Parameters:
- ADDR_W, 32, PC/address width.
- VECTOR_ADDR, 1, handler entry address driven on redirect_pc at entry.
- CNT_W, 16, width of serviced-interrupt counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- intCPU  in  1  interrupt request from controller; held until intDisabled seen high.
- intID  in  8  ID of requested interrupt (1..8); valid while intCPU=1.
- boundary_valid  in  1  commit stage is at an instruction boundary where an interrupt may be taken.
- boundary_pc  in  ADDR_W  PC of next instruction to execute at that boundary.
- reti_commit  in  1  reti instruction committing this cycle (single-cycle pulse).
- intDisabled  out  1  interrupts masked / in handler; also ack to controller.
- redirect_valid  out  1  one-cycle pulse: flush pipeline, fetch from redirect_pc.
- redirect_pc  out  ADDR_W  redirect target; valid when redirect_valid=1.
- epc  out  ADDR_W  saved return PC, software-readable.
- cur_id  out  8  ID of interrupt being serviced, software-readable.
- int_count  out  CNT_W  number of interrupts entered, wraps.
- spurious_reti  out  1  sticky: reti committed while not in a handler.

Behaviour:
- States: IDLE, HANDLER, RETURN. All outputs are registered.
- Reset (reset=0, async) forces:
  - state=IDLE;
  - intDisabled=0, redirect_valid=0, redirect_pc=0, epc=0, cur_id=0, int_count=0, spurious_reti=0.
- IDLE, intDisabled=0:
  - If intCPU=1 and boundary_valid=1 in cycle N, then at edge N+1:
    - epc<=boundary_pc, cur_id<=intID;
    - intDisabled<=1, redirect_valid<=1, redirect_pc<=VECTOR_ADDR;
    - int_count<=int_count+1, modulo 2^CNT_W;
    - state<=HANDLER.
  - If intCPU=1 and boundary_valid=0: stay in IDLE, nothing captured. The request stays pending because the controller holds intCPU.
  - reti_commit=1 in IDLE: no redirect, no state change, spurious_reti<=1.
  - intCPU and reti_commit both high with boundary_valid=1: entry wins and spurious_reti is set in the same edge.
- HANDLER, intDisabled=1:
  - redirect_valid is high only in the first cycle after entry, then 0.
  - intCPU and intID are ignored; intCPU will have dropped, since the controller clears it on intDisabled.
  - reti_commit=1 in cycle M: at M+1, redirect_valid<=1, redirect_pc<=epc, state<=RETURN; intDisabled stays 1.
- RETURN: one cycle.
  - redirect_valid<=0, intDisabled<=0, state<=IDLE.
  - intDisabled therefore falls two edges after the reti commit, so the restored PC is in fetch before a new interrupt can be accepted.
  - reti_commit in RETURN is ignored; it cannot legally occur after a flush.
- Latency: request at boundary to vector redirect = 1 cycle; reti commit to redirect = 1 cycle; reti commit to interrupts re-enabled = 2 cycles.
- epc and cur_id hold their values after return until the next entry.
- Reset mid-handler returns to IDLE with interrupts enabled. No redirect is issued; the CPU reset vector governs fetch.

Decomposition:
- Shared CPU package:
  - state encoding (IDLE=2'd0, HANDLER=2'd1, RETURN=2'd2);
  - INT_VECTOR_ADDR constant, aliased to VECTOR_ADDR;
  - interrupt ID width (8).
- No sub-module is warranted: a single FSM plus capture registers and a counter.

Test Plan:
1. Reset release, then intCPU=1, intID=3, boundary_valid=1, boundary_pc=0x100 in cycle N → at N+1: redirect_valid=1, redirect_pc=1, intDisabled=1, epc=0x100, cur_id=3, int_count=1.
2. intCPU=1 with boundary_valid=0 for 5 cycles, then boundary_valid=1 with boundary_pc=0x240 → no redirect during the wait; entry on the cycle after boundary_valid with epc=0x240.
3. From HANDLER with epc=0x100, pulse reti_commit at cycle M → at M+1: redirect_valid=1, redirect_pc=0x100, intDisabled=1; at M+2: intDisabled=0, state IDLE.
4. reti_commit in IDLE → no redirect_valid, spurious_reti=1 and held until reset; in the same cycle as a valid entry, entry still occurs.
5. Assert reset=0 while in HANDLER mid-cycle → all outputs 0 immediately (asynchronous); after release, a new intCPU request is serviced normally.
6. With CNT_W=2, perform 5 entry/return cycles → int_count sequence 1,2,3,0,1.
